// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decode-stage fields, branch outcome and memory ready in;
// pipeline stall/flush/freeze controls, forwarding selects and stall counter out.
interface hazard_ctrl_if #(
   parameter int unsigned ADW = 5,
   parameter int unsigned CW  = 16
);
   logic           validD;
   logic [ADW-1:0] Rs1D;
   logic [ADW-1:0] Rs2D;
   logic [ADW-1:0] RdD;
   logic           regwriteD;
   logic           resultsrcD;
   logic           memwriteD;
   logic           PCSrcE;
   logic           mem_ready;
   logic           stallF;
   logic           stallD;
   logic           flushD;
   logic           flushE;
   logic           stallE;
   logic           stallM;
   logic [1:0]     forwardAE;
   logic [1:0]     forwardBE;
   logic [CW-1:0]  stall_cnt;

   // Pipeline side: drives decode fields, observes controls
   modport master (
      output validD, Rs1D, Rs2D, RdD, regwriteD, resultsrcD, memwriteD, PCSrcE, mem_ready,
      input  stallF, stallD, flushD, flushE, stallE, stallM, forwardAE, forwardBE, stall_cnt
   );

   // Controller side
   modport slave (
      input  validD, Rs1D, Rs2D, RdD, regwriteD, resultsrcD, memwriteD, PCSrcE, mem_ready,
      output stallF, stallD, flushD, flushE, stallE, stallM, forwardAE, forwardBE, stall_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage RV32I hazard controller with a private E/M/W destination scoreboard.
// Optional feature macro HAZARD_FWD_EN: when defined, execute-stage forwarding is
// enabled and only load-use stalls; when undefined, selects are 00 and any pending
// writer of a decode source stalls.
module hazard_ctrl #(
   parameter int unsigned ADW = 5,
   parameter int unsigned CW  = 16
) (
   input logic          clk,
   input logic          rst,
   hazard_ctrl_if.slave bus
);

   typedef enum logic {StRun, StMemWait} state_e;

   state_e state_q, state_d;

   // Scoreboard slots (E also carries its source indices when forwarding)
   logic           e_valid_q, e_valid_d, e_regwrite_q, e_regwrite_d, e_memop_q, e_memop_d;
   logic [ADW-1:0] e_rd_q, e_rd_d;
   logic           m_valid_q, m_valid_d, m_regwrite_q, m_regwrite_d, m_memop_q, m_memop_d;
   logic [ADW-1:0] m_rd_q, m_rd_d;
   logic           w_valid_q, w_valid_d, w_regwrite_q, w_regwrite_d;
   logic [ADW-1:0] w_rd_q, w_rd_d;
   logic [CW-1:0]  stall_cnt_q, stall_cnt_d;

   logic freeze, data_haz;
   logic stall_f, stall_d, flush_d, flush_e, stall_e, stall_m;

   function automatic logic wmatch(input logic v, input logic rw, input logic [ADW-1:0] rd,
                                   input logic [ADW-1:0] src);
      return v & rw & (rd != '0) & (rd == src);
   endfunction

   assign freeze = m_valid_q & m_memop_q & ~bus.mem_ready;

`ifdef HAZARD_FWD_EN
   logic           e_load_q, e_load_d;
   logic [ADW-1:0] e_rs1_q, e_rs1_d, e_rs2_q, e_rs2_d;

   // Load-use: only a load still in E cannot be forwarded in time
   assign data_haz = bus.validD & e_load_q &
                     (wmatch(e_valid_q, e_regwrite_q, e_rd_q, bus.Rs1D) |
                      wmatch(e_valid_q, e_regwrite_q, e_rd_q, bus.Rs2D));

   // Forward selects for the E operands; M is younger so it wins over W
   always_comb begin
      bus.forwardAE = 2'b00;
      bus.forwardBE = 2'b00;
      if (wmatch(m_valid_q, m_regwrite_q, m_rd_q, e_rs1_q))      bus.forwardAE = 2'b10;
      else if (wmatch(w_valid_q, w_regwrite_q, w_rd_q, e_rs1_q)) bus.forwardAE = 2'b01;
      if (wmatch(m_valid_q, m_regwrite_q, m_rd_q, e_rs2_q))      bus.forwardBE = 2'b10;
      else if (wmatch(w_valid_q, w_regwrite_q, w_rd_q, e_rs2_q)) bus.forwardBE = 2'b01;
   end

   // Extra E fields needed only for forwarding
   always_comb begin
      e_load_d = e_load_q;
      e_rs1_d  = e_rs1_q;
      e_rs2_d  = e_rs2_q;
      if (!freeze && !flush_e) begin
         e_load_d = bus.resultsrcD;
         e_rs1_d  = bus.Rs1D;
         e_rs2_d  = bus.Rs2D;
      end
   end

   // Extra E field registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_load_q <= 1'b0;
         e_rs1_q  <= '0;
         e_rs2_q  <= '0;
      end else begin
         e_load_q <= e_load_d;
         e_rs1_q  <= e_rs1_d;
         e_rs2_q  <= e_rs2_d;
      end
   end
`else
   // Without forwarding any in-flight writer of a decode source must drain first
   assign data_haz = bus.validD &
                     (wmatch(e_valid_q, e_regwrite_q, e_rd_q, bus.Rs1D) |
                      wmatch(e_valid_q, e_regwrite_q, e_rd_q, bus.Rs2D) |
                      wmatch(m_valid_q, m_regwrite_q, m_rd_q, bus.Rs1D) |
                      wmatch(m_valid_q, m_regwrite_q, m_rd_q, bus.Rs2D) |
                      wmatch(w_valid_q, w_regwrite_q, w_rd_q, bus.Rs1D) |
                      wmatch(w_valid_q, w_regwrite_q, w_rd_q, bus.Rs2D));
   assign bus.forwardAE = 2'b00;
   assign bus.forwardBE = 2'b00;
`endif

   // Prioritised pipeline controls: freeze > branch > data hazard
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      if (freeze) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
      end else if (bus.PCSrcE) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (data_haz) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

   assign bus.stallF    = stall_f;
   assign bus.stallD    = stall_d;
   assign bus.flushD    = flush_d;
   assign bus.flushE    = flush_e;
   assign bus.stallE    = stall_e;
   assign bus.stallM    = stall_m;
   assign bus.stall_cnt = stall_cnt_q;

   // Scoreboard advance, memory-wait state and stall counter next-state
   always_comb begin
      e_valid_d    = e_valid_q;
      e_regwrite_d = e_regwrite_q;
      e_memop_d    = e_memop_q;
      e_rd_d       = e_rd_q;
      m_valid_d    = m_valid_q;
      m_regwrite_d = m_regwrite_q;
      m_memop_d    = m_memop_q;
      m_rd_d       = m_rd_q;
      w_valid_d    = 1'b0;
      w_regwrite_d = m_regwrite_q;
      w_rd_d       = m_rd_q;
      if (!freeze) begin
         w_valid_d    = m_valid_q;
         m_valid_d    = e_valid_q;
         m_regwrite_d = e_regwrite_q;
         m_memop_d    = e_memop_q;
         m_rd_d       = e_rd_q;
         if (flush_e) begin
            e_valid_d = 1'b0;
         end else begin
            e_valid_d    = bus.validD;
            e_regwrite_d = bus.regwriteD;
            e_memop_d    = bus.resultsrcD | bus.memwriteD;
            e_rd_d       = bus.RdD;
         end
      end

      state_d = state_q;
      unique case (state_q)
         StRun:     if (freeze) state_d = StMemWait;
         StMemWait: if (bus.mem_ready) state_d = StRun;
         default:   state_d = StRun;
      endcase

      stall_cnt_d = stall_cnt_q;
      if (stall_d && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CW'(1);
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StRun;
         e_valid_q    <= 1'b0;
         e_regwrite_q <= 1'b0;
         e_memop_q    <= 1'b0;
         e_rd_q       <= '0;
         m_valid_q    <= 1'b0;
         m_regwrite_q <= 1'b0;
         m_memop_q    <= 1'b0;
         m_rd_q       <= '0;
         w_valid_q    <= 1'b0;
         w_regwrite_q <= 1'b0;
         w_rd_q       <= '0;
         stall_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         e_valid_q    <= e_valid_d;
         e_regwrite_q <= e_regwrite_d;
         e_memop_q    <= e_memop_d;
         e_rd_q       <= e_rd_d;
         m_valid_q    <= m_valid_d;
         m_regwrite_q <= m_regwrite_d;
         m_memop_q    <= m_memop_d;
         m_rd_q       <= m_rd_d;
         w_valid_q    <= w_valid_d;
         w_regwrite_q <= w_regwrite_d;
         w_rd_q       <= w_rd_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations follow the HAZARD_FWD_EN setting.
module tb_hazard_ctrl;

   // Control vector order: {stallF, stallD, flushD, flushE, stallE, stallM}
   localparam logic [5:0] CNone = 6'b000000;
   localparam logic [5:0] CLu   = 6'b110100;
   localparam logic [5:0] CBr   = 6'b001100;
   localparam logic [5:0] CFrz  = 6'b110011;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total  = 0;
   int   passed = 0;
   int   fails  = 0;

   hazard_ctrl_if #(.ADW(5), .CW(16)) hz ();
   hazard_ctrl #(.ADW(5), .CW(16)) dut (.clk(clk), .rst(rst), .bus(hz));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctrl(input string tag, input logic [5:0] exp);
      chk(tag, {26'd0, hz.stallF, hz.stallD, hz.flushD, hz.flushE, hz.stallE, hz.stallM},
          {26'd0, exp});
   endtask

   task automatic chk_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
      chk(tag, {28'd0, hz.forwardAE, hz.forwardBE}, {28'd0, a, b});
   endtask

   task automatic chk_cnt(input string tag, input int exp);
      chk(tag, {16'd0, hz.stall_cnt}, exp);
   endtask

   task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic rw, input logic ld, input logic st);
      hz.validD     = v;
      hz.Rs1D       = rs1;
      hz.Rs2D       = rs2;
      hz.RdD        = rd;
      hz.regwriteD  = rw;
      hz.resultsrcD = ld;
      hz.memwriteD  = st;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      hz.PCSrcE    = 1'b0;
      hz.mem_ready = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // Reset state
      do_reset();
      #1;
      chk_ctrl("reset_ctrl", CNone);
      chk_fwd("reset_fwd", 2'b00, 2'b00);
      chk_cnt("reset_cnt", 0);

      // add x5,x1,x2 ; sub x6,x5,x7
      drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
      #1 chk_ctrl("add_first", CNone);
      tick();
      drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b0);
      #1;
`ifdef HAZARD_FWD_EN
      chk_ctrl("sub_in_d", CNone);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk_fwd("sub_in_e_fwd", 2'b10, 2'b00);
      chk_ctrl("sub_in_e_ctrl", CNone);
      chk_cnt("sub_cnt", 0);
`else
      chk_ctrl("sub_stall_e", CLu);
      tick();
      #1 chk_ctrl("sub_stall_m", CLu);
      tick();
      #1 chk_ctrl("sub_stall_w", CLu);
      tick();
      #1 chk_ctrl("sub_release", CNone);
      chk_cnt("sub_cnt", 3);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 chk_fwd("sub_in_e_fwd", 2'b00, 2'b00);
`endif

      // lw x5,0(x1) ; add x6,x5,x5
      do_reset();
      drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
      #1 chk_ctrl("lu_stall", CLu);
      tick();
`ifdef HAZARD_FWD_EN
      #1 chk_ctrl("lu_release", CNone);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 chk_fwd("lu_fwd_w", 2'b01, 2'b01);
      chk_cnt("lu_cnt", 1);
`else
      #1 chk_ctrl("lu_stall_m", CLu);
      tick();
      #1 chk_ctrl("lu_stall_w", CLu);
      tick();
      #1 chk_ctrl("lu_release", CNone);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 chk_fwd("lu_fwd_w", 2'b00, 2'b00);
      chk_cnt("lu_cnt", 3);
`endif

      // addi x0 ; add x8,x0,x0
      do_reset();
      drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
      #1 chk_ctrl("x0_no_stall", CNone);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 chk_fwd("x0_fwd", 2'b00, 2'b00);
      chk_cnt("x0_cnt", 0);

      // lw x5 in M held by memory for 3 cycles while a taken branch sits in E
      do_reset();
      drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 chk_ctrl("frz_pre", CNone);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      hz.mem_ready = 1'b0;
      hz.PCSrcE    = 1'b1;
      #1 chk_ctrl("frz_c1", CFrz);
      tick();
      #1 chk_ctrl("frz_c2", CFrz);
      tick();
      #1 chk_ctrl("frz_c3", CFrz);
      tick();
      hz.mem_ready = 1'b1;
      #1 chk_ctrl("frz_branch", CBr);
      chk_cnt("frz_cnt", 3);

      // Async reset in the middle of a memory wait
      do_reset();
      drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      hz.mem_ready = 1'b0;
      #1 chk_ctrl("mw_freeze", CFrz);
      tick();
      #1 chk_cnt("mw_cnt", 1);
      rst = 1'b1;
      #1;
      chk_ctrl("mw_rst_ctrl", CNone);
      chk_fwd("mw_rst_fwd", 2'b00, 2'b00);
      chk_cnt("mw_rst_cnt", 0);
      rst = 1'b0;
      tick();
      #1 chk_ctrl("mw_after", CNone);
      chk_cnt("mw_after_cnt", 0);
      hz.mem_ready = 1'b1;

      // Branch and load-use together: branch wins, no stall
      do_reset();
      drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
      hz.PCSrcE = 1'b1;
      #1 chk_ctrl("br_lu", CBr);
      tick();
      hz.PCSrcE = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 chk_cnt("br_lu_cnt", 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
